// File: rtl/mole_ctrl.sv
// mole_ctrl: whack-a-mole round controller with hit/miss pulses and saturating score
module mole_ctrl #(
  parameter int TIMEOUT_TICKS = 3,
  parameter int SCORE_W = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               enable,
  input  logic               tick,
  input  logic [3:0]         pos,
  input  logic [6:0]         btn,
  output logic [6:0]         mole_led,
  output logic [2:0]         mole_idx,
  output logic               hit,
  output logic               miss,
  output logic [SCORE_W-1:0] score
);
  typedef enum logic [1:0] {IDLE, WAIT, UP} state_t;
  state_t r_state, w_state_n;
  logic [2:0] r_idx, w_idx_n;
  logic [3:0] r_life, w_life_n;
  logic [6:0] r_led, w_led_n;
  logic r_hit, w_hit_n, r_miss, w_miss_n;
  logic [SCORE_W-1:0] r_score, w_score_n;
  assign mole_led = r_led;
  assign mole_idx = r_idx;
  assign hit = r_hit;
  assign miss = r_miss;
  assign score = r_score;
  // state and all registered outputs; clr discards any pending mole at once
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_life <= '0;
      r_led <= '0;
      r_hit <= 1'b0;
      r_miss <= 1'b0;
      r_score <= '0;
    end else begin
      r_state <= w_state_n;
      r_idx <= w_idx_n;
      r_life <= w_life_n;
      r_led <= w_led_n;
      r_hit <= w_hit_n;
      r_miss <= w_miss_n;
      r_score <= w_score_n;
    end
  end
  // round sequencing: the matching button beats a wrong button, which beats a timeout tick
  always_comb begin
    w_state_n = r_state;
    w_idx_n = r_idx;
    w_life_n = r_life;
    w_hit_n = 1'b0;
    w_miss_n = 1'b0;
    w_score_n = r_score;
    if (!enable) w_state_n = IDLE;
    else begin
      case (r_state)
        IDLE: w_state_n = WAIT;
        WAIT: if (tick) begin
          w_state_n = UP;
          w_idx_n = (pos <= 4'd6) ? pos[2:0] : 3'd0;
          w_life_n = 4'(TIMEOUT_TICKS);
        end
        UP: if (btn[r_idx]) begin
          w_hit_n = 1'b1;
          w_score_n = (r_score == '1) ? r_score : r_score + 1'b1;
          w_state_n = WAIT;
        end else if (|btn) begin
          w_miss_n = 1'b1;
          w_state_n = WAIT;
        end else if (tick) begin
          w_miss_n = (r_life == 4'd1);
          w_state_n = (r_life == 4'd1) ? WAIT : UP;
          w_life_n = (r_life == 4'd1) ? r_life : r_life - 4'd1;
        end
        default: w_state_n = IDLE;
      endcase
    end
    w_led_n = (w_state_n == UP) ? 7'b1 << w_idx_n : 7'b0;
  end
endmodule

// File: tb/tb_mole_ctrl.sv
// tb_mole_ctrl: directed plus random checking of mole_ctrl against a round-level model
module tb_mole_ctrl;
  localparam int T = 3;
  logic clk = 1'b0, clr = 1'b1, enable = 1'b0, tick = 1'b0;
  logic [3:0] pos = '0;
  logic [6:0] btn = '0;
  logic [6:0] led, s_led;
  logic [2:0] idx, s_idx;
  logic hit, miss, s_hit, s_miss;
  logic [7:0] score;
  logic [1:0] s_score;
  int n_vec = 0, n_err = 0;
  bit m_run, m_up, m_hit, m_miss;
  int m_idx, m_rem, m_hits;
  int seq [5] = '{1, 2, 3, 3, 3};

  mole_ctrl #(.TIMEOUT_TICKS(T), .SCORE_W(8)) u_dut (
    .clk(clk), .clr(clr), .enable(enable), .tick(tick), .pos(pos), .btn(btn),
    .mole_led(led), .mole_idx(idx), .hit(hit), .miss(miss), .score(score));
  mole_ctrl #(.TIMEOUT_TICKS(T), .SCORE_W(2)) u_sat (
    .clk(clk), .clr(clr), .enable(enable), .tick(tick), .pos(pos), .btn(btn),
    .mole_led(s_led), .mole_idx(s_idx), .hit(s_hit), .miss(s_miss), .score(s_score));

  always #5 clk = ~clk;

  function void model_reset();
    m_run = 0; m_up = 0; m_hit = 0; m_miss = 0; m_idx = 0; m_rem = 0; m_hits = 0;
  endfunction

  function void model_step();
    m_hit = 0; m_miss = 0;
    if (!enable) begin m_run = 0; m_up = 0; end
    else if (!m_run) m_run = 1;
    else if (!m_up) begin
      if (tick) begin m_up = 1; m_idx = (pos < 7) ? int'(pos) : 0; m_rem = T; end
    end else if (btn[m_idx]) begin m_hit = 1; m_hits++; m_up = 0; end
    else if (btn != 0) begin m_miss = 1; m_up = 0; end
    else if (tick) begin
      m_rem--;
      if (m_rem == 0) begin m_miss = 1; m_up = 0; end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int e_led;
    e_led = m_up ? (1 << m_idx) : 0;
    chk("mole_led", 32'(led), e_led);
    chk("mole_idx", 32'(idx), m_idx);
    chk("hit", 32'(hit), 32'(m_hit));
    chk("miss", 32'(miss), 32'(m_miss));
    chk("score", 32'(score), (m_hits > 255) ? 255 : m_hits);
    chk("sat_led", 32'(s_led), e_led);
    chk("sat_hit", 32'(s_hit), 32'(m_hit));
    chk("sat_miss", 32'(s_miss), 32'(m_miss));
    chk("sat_score", 32'(s_score), (m_hits > 3) ? 3 : m_hits);
    chk("pulse_excl", 32'(hit & miss), 0);
  endtask

  task automatic apply(input bit en, input bit tk, input int p, input logic [6:0] b);
    enable = en; tick = tk; pos = 4'(p); btn = b;
    @(posedge clk);
    model_step();
    #1 check_all();
  endtask

  task automatic async_clr();
    #2 clr = 1'b1;
    #1 model_reset();
    check_all();
    chk("clr_led", 32'(led), 0);
    chk("clr_score", 32'(score), 0);
    #1 clr = 1'b0;
  endtask

  initial begin
    int r;
    logic [6:0] b;
    model_reset();
    #12 check_all();
    clr = 1'b0;
    apply(1, 0, 0, 0);
    chk("pre_spawn_led", 32'(led), 0);
    apply(1, 1, 5, 0);
    chk("spawn_led", 32'(led), 32'h20);
    chk("spawn_idx", 32'(idx), 5);
    apply(1, 0, 0, 7'b0100000);
    chk("hit_pulse", 32'(hit), 1);
    chk("hit_score", 32'(score), 1);
    chk("hit_led", 32'(led), 0);
    apply(1, 0, 0, 0);
    chk("hit_one_cycle", 32'(hit), 0);
    apply(1, 1, 4, 0);
    chk("respawn_idx", 32'(idx), 4);
    apply(1, 0, 0, 7'b0000001);
    chk("wrong_miss", 32'(miss), 1);
    chk("wrong_score", 32'(score), 1);
    apply(1, 1, 2, 0);
    apply(1, 0, 0, 7'b0000001);
    chk("wrong2_miss", 32'(miss), 1);
    apply(1, 1, 3, 0);
    apply(1, 0, 0, 7'b0001001);
    chk("mixed_hit", 32'(hit), 1);
    chk("mixed_score", 32'(score), 2);
    apply(1, 1, 6, 0);
    apply(1, 1, 0, 0);
    apply(1, 1, 0, 0);
    apply(1, 0, 0, 0);
    chk("timeout_not_yet", 32'(miss), 0);
    apply(1, 1, 0, 0);
    chk("timeout_miss", 32'(miss), 1);
    chk("timeout_led", 32'(led), 0);
    apply(1, 0, 0, 0);
    chk("timeout_one_cycle", 32'(miss), 0);
    apply(1, 1, 1, 0);
    apply(1, 1, 0, 0);
    apply(1, 1, 0, 0);
    apply(1, 1, 0, 7'b0000010);
    chk("race_hit", 32'(hit), 1);
    chk("race_no_miss", 32'(miss), 0);
    async_clr();
    apply(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      apply(1, 1, (i == 0) ? 9 : i, 0);
      if (i == 0) chk("invalid_pos_idx", 32'(idx), 0);
      b = 7'(1 << ((i == 0) ? 0 : i));
      apply(1, 0, 0, b);
      chk("sat_seq", 32'(s_score), seq[i]);
    end
    apply(1, 1, 2, 0);
    apply(0, 0, 0, 7'b1111111);
    chk("abort_led", 32'(led), 0);
    chk("abort_hit", 32'(hit), 0);
    chk("abort_miss", 32'(miss), 0);
    chk("abort_score", 32'(score), 5);
    apply(1, 0, 0, 0);
    apply(1, 1, 3, 0);
    async_clr();
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      b = (r < 6) ? 7'b0 : (r < 8) ? 7'(1 << (m_up ? m_idx : $urandom_range(0, 6))) : 7'($urandom);
      apply($urandom_range(0, 24) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 9), b);
      if ($urandom_range(0, 299) == 0) async_clr();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mole_ctrl.md
# mole_ctrl

Whack-a-mole round controller; consumes the 0..6 position value produced by the game's mod-7 down counter. On each game tick it latches the counter value as the active mole, lights that mole's LED, and waits for the matching button or a timeout. It emits single-cycle hit/miss pulses and keeps a saturating score for the display stage.

## Interface
- TIMEOUT_TICKS, 3: ticks a mole stays up before a miss is declared (1..15).
- SCORE_W, 8: score width in bits.

- clk  in  1  system clock, all state on rising edge.
- clr  in  1  reset, asynchronous, active-high.
- enable  in  1  game running; low forces IDLE.
- tick  in  1  single-cycle game-time pulse, same pulse that drives the counter's cnt.
- pos  in  4  mole position from mod-7 down counter; valid values 0..6.
- btn  in  7  debounced single-cycle button pulses, bit i = mole i.
- mole_led  out  7  one-hot active mole, all zero when no mole is up.
- mole_idx  out  3  index of the latched mole (held after mole drops).
- hit  out  1  one-cycle pulse, correct whack.
- miss  out  1  one-cycle pulse, wrong button or timeout.
- score  out  SCORE_W  number of hits, saturating.

## Operation
- States: IDLE, WAIT, UP.
- IDLE: mole_led=0. enable=1 -> WAIT.
- WAIT: mole_led=0. On tick: latch idx = pos if pos<=6, else idx=0; load life counter with TIMEOUT_TICKS; -> UP.
- UP: mole_led = 1<<idx. Evaluated each cycle, priority order:
  - btn[idx]=1 (other bits ignored) -> hit pulse, score+1 (hold at 2^SCORE_W-1), -> WAIT.
  - btn!=0 and btn[idx]=0 -> miss pulse, -> WAIT.
  - tick and life==1 -> miss pulse, -> WAIT.
  - tick and life>1 -> life-1, stay UP.
- A tick in UP never spawns a new mole in the same cycle; the next mole spawns on the next tick seen in WAIT.
- Same position on consecutive spawns is legal.
- enable=0 in any state -> IDLE next cycle; no hit/miss pulse generated for the abandoned mole; score held.
- score cleared only by clr.
- Arithmetic: life counter 4 bits; score increments modulo-free (saturating), no wrap.

## Timing
- All outputs registered. Reset values: state=IDLE, mole_led=0, mole_idx=0, hit=0, miss=0, score=0, life=0.
- clr asserted mid-round: immediate (asynchronous) return to reset values; pending mole discarded.
- Spawn latency: tick at cycle N in WAIT -> mole_led valid at N+1, mole_idx updated at N+1.
- Whack latency: btn at cycle N in UP -> hit or miss high at N+1, mole_led=0 at N+1, score updated at N+1.
- Timeout: mole up at N+1 from spawn; miss on the cycle after the TIMEOUT_TICKS-th subsequent tick.
- hit and miss never high in the same cycle; each high for exactly one cycle per event.
- Simultaneous btn[idx] and timeout tick in same cycle -> hit wins.
- Simultaneous enable fall and btn -> IDLE, no pulse.

## Test plan
- Reset/spawn: clr pulse, enable=1, pos=5, tick at N -> mole_led=7'b0100000, mole_idx=5 at N+1; all outputs zero before.
- Hit: mole 5 up, btn=7'b0100000 at M -> hit=1 for one cycle at M+1, score 0->1, mole_led=0; next tick with pos=4 spawns mole 4.
- Wrong button and mixed press: mole 2 up, btn=7'b0000001 -> miss, score unchanged; mole 3 up, btn=7'b0001001 -> hit.
- Timeout: TIMEOUT_TICKS=3, mole up, three ticks with no btn -> miss one cycle after third tick; btn + third tick in same cycle -> hit, no miss.
- Saturation: SCORE_W=2, five hits -> score sequence 1,2,3,3,3; invalid pos=9 on spawn -> mole_idx=0.
- Abort: enable dropped while mole up -> IDLE, mole_led=0, no pulse, score held; clr mid-UP -> all outputs zero asynchronously.
